// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED pattern generator.
//   mode_t   - animation mode encoding, matches the 2-bit `mode` input
//   SEED_PAT - single-lit starting pattern for CHASE/BOUNCE
//   LED_W    - width of the LED drive
package led_pkg;

  localparam int LED_W = 32'd8;

  localparam logic [LED_W-1:0] SEED_PAT = 8'h01;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_t;

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler plus rate divider producing the pattern step tick.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - advance the prescaler; 0 freezes both counters
//   clr        - synchronous clear of prescaler and divider (mode change)
//   rate       - tick period is (rate+1) prescaler wraps
//   tick       - one-cycle strobe, high on the cycle the divider matches on a wrap
module led_tick_gen #(
  parameter int PRESCALE_W = 32'd16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [3:0] rate,
  output logic       tick
);

  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PRESC_MAX  = {PRESCALE_W{1'b1}};
  localparam logic [PRESCALE_W-1:0] PRESC_ZERO = {PRESCALE_W{1'b0}};

  logic [PRESCALE_W-1:0] presc_r;
  logic [3:0]            div_r;
  logic                  wrap_s;

  // Wrap detection and tick strobe; a clear cycle never produces a tick.
  always_comb begin
    wrap_s = en && (presc_r == PRESC_MAX);
    if (clr) begin
      tick = 1'b0;
    end else begin
      tick = wrap_s && (div_r == rate);
    end
  end

  // Prescaler and divider. A divider above a newly lowered rate simply
  // runs up to its own wrap and restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= PRESC_ZERO;
      div_r   <= 4'd0;
    end else if (clr) begin
      presc_r <= PRESC_ZERO;
      div_r   <= 4'd0;
    end else if (en) begin
      presc_r <= presc_r + PRESC_ONE;
      if (wrap_s) begin
        if (div_r == rate) begin
          div_r <= 4'd0;
        end else begin
          div_r <= div_r + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: animated, PWM-dimmed 8-bit LED pattern generator.
//   clk, rst_n - clock, asynchronous active-low reset
//   en         - run enable for the step timing (PWM always runs)
//   mode       - 00 STATIC, 01 CHASE, 10 BOUNCE, 11 BLINK
//   rate       - step period (rate+1) * 2^PRESCALE_W cycles
//   duty       - brightness; all-ones is fully lit, zero is dark
//   load       - strobe capturing load_pat into the stored pattern
//   load_pat   - pattern used by STATIC/BLINK
//   led        - registered LED drive
//   step       - one-cycle pulse on each pattern advance
//   dir        - BOUNCE direction, 0 = toward bit 7
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int PRESCALE_W = 32'd16,
  parameter int PWM_W      = 32'd4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [3:0]       rate,
  input  logic [PWM_W-1:0] duty,
  input  logic             load,
  input  logic [LED_W-1:0] load_pat,
  output logic [LED_W-1:0] led,
  output logic             step,
  output logic             dir
);

  localparam logic [PWM_W-1:0] PWM_ONE  = {{(PWM_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_W-1:0] PWM_FULL = {PWM_W{1'b1}};

  mode_t            mode_q_r;
  mode_t            mode_in_s;
  mode_t            mode_q_nx_s;
  logic [LED_W-1:0] pattern_r;
  logic [LED_W-1:0] pattern_nx_s;
  logic [LED_W-1:0] pat_reg_r;
  logic [LED_W-1:0] pat_reg_nx_s;
  logic [PWM_W-1:0] pwm_cnt_r;
  logic             dir_nx_s;
  logic             step_nx_s;
  logic             mode_chg_s;
  logic             tick_s;
  logic             lit_s;
  logic [LED_W-1:0] led_nx_s;

  // A mode change restarts the step period so the first step is a full period away.
  led_tick_gen #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (mode_chg_s),
    .rate  (rate),
    .tick  (tick_s)
  );

  // Next-state logic: mode change beats load, load beats tick (step still flagged).
  always_comb begin
    mode_in_s    = mode_t'(mode);
    mode_chg_s   = (mode_in_s != mode_q_r);
    mode_q_nx_s  = mode_q_r;
    pattern_nx_s = pattern_r;
    dir_nx_s     = dir;
    step_nx_s    = 1'b0;
    if (load) begin
      pat_reg_nx_s = load_pat;
    end else begin
      pat_reg_nx_s = pat_reg_r;
    end

    if (mode_chg_s) begin
      mode_q_nx_s = mode_in_s;
      case (mode_in_s)
        MODE_CHASE, MODE_BOUNCE: begin
          pattern_nx_s = SEED_PAT;
          dir_nx_s     = 1'b0;
        end
        MODE_STATIC, MODE_BLINK: pattern_nx_s = pat_reg_r;
        default: begin
          pattern_nx_s = SEED_PAT;
          dir_nx_s     = 1'b0;
        end
      endcase
    end else if (load && ((mode_q_r == MODE_STATIC) || (mode_q_r == MODE_BLINK))) begin
      pattern_nx_s = load_pat;
      step_nx_s    = tick_s;
    end else if (tick_s) begin
      step_nx_s = 1'b1;
      case (mode_q_r)
        MODE_STATIC: pattern_nx_s = pat_reg_r;
        MODE_CHASE:  pattern_nx_s = {pattern_r[LED_W-2:0], pattern_r[LED_W-1]};
        MODE_BOUNCE: begin
          // Direction flips in the same update that reaches an end bit.
          if (!dir) begin
            pattern_nx_s = {pattern_r[LED_W-2:0], 1'b0};
            if (pattern_nx_s == 8'h80) begin
              dir_nx_s = 1'b1;
            end else begin
              dir_nx_s = 1'b0;
            end
          end else begin
            pattern_nx_s = {1'b0, pattern_r[LED_W-1:1]};
            if (pattern_nx_s == 8'h01) begin
              dir_nx_s = 1'b0;
            end else begin
              dir_nx_s = 1'b1;
            end
          end
        end
        MODE_BLINK: begin
          if (pattern_r != 8'h00) begin
            pattern_nx_s = 8'h00;
          end else begin
            pattern_nx_s = pat_reg_r;
          end
        end
        default: pattern_nx_s = SEED_PAT;
      endcase
    end else begin
      pattern_nx_s = pattern_r;
    end
  end

  // PWM gate: all-ones duty forces the LEDs fully on.
  always_comb begin
    lit_s    = (duty == PWM_FULL) || (pwm_cnt_r < duty);
    led_nx_s = pattern_r & {LED_W{lit_s}};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q_r  <= MODE_STATIC;
      pattern_r <= SEED_PAT;
      pat_reg_r <= SEED_PAT;
      pwm_cnt_r <= {PWM_W{1'b0}};
      dir       <= 1'b0;
      step      <= 1'b0;
      led       <= {LED_W{1'b0}};
    end else begin
      mode_q_r  <= mode_q_nx_s;
      pattern_r <= pattern_nx_s;
      pat_reg_r <= pat_reg_nx_s;
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      dir       <= dir_nx_s;
      step      <= step_nx_s;
      led       <= led_nx_s;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: self-checking bench for led_pattern_gen with
// PRESCALE_W = 2 (4-cycle base period) and PWM_W = 4.
module tb_led_pattern_gen;

  typedef struct {
    logic [7:0] led;
    logic       dir;
    logic       chk_dir;
  } exp_t;

  typedef struct {
    logic [3:0] duty;
    int         lit;
  } pwm_vec_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] rate;
  logic [3:0] duty;
  logic       load;
  logic [7:0] load_pat;
  logic [7:0] led;
  logic       step;
  logic       dir;

  int   tests;
  int   fails;
  exp_t sb[$];

  led_pattern_gen #(.PRESCALE_W(2), .PWM_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .rate     (rate),
    .duty     (duty),
    .load     (load),
    .load_pat (load_pat),
    .led      (led),
    .step     (step),
    .dir      (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_step(input string nm, output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #2;
      n++;
      if (step === 1'b1) break;
    end
    if (step !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL %s: no step within %0d cycles", nm, n);
    end
  endtask

  task automatic push(input logic [7:0] l, input logic d, input logic cd);
    exp_t e;
    e.led = l;
    e.dir = d;
    e.chk_dir = cd;
    sb.push_back(e);
  endtask

  // Pops one expected entry per step: checks step spacing, dir, then led a cycle later.
  task automatic run_seq(input string nm, input int cnt, input int first_n, input int gap_n);
    int   n;
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      wait_step(nm, n);
      chk({nm, "_gap"}, n, (i == 0) ? first_n : gap_n);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL %s: scoreboard empty", nm);
      end else begin
        e = sb.pop_front();
        if (e.chk_dir) chk({nm, "_dir"}, dir, e.dir);
        cyc(1);
        chk({nm, "_led"}, led, e.led);
      end
    end
  endtask

  initial begin
    pwm_vec_t   pwm_tbl[5];
    logic [7:0] chase_exp[8];
    logic [7:0] bounce_exp[16];
    logic       bounce_dir[16];
    int         n;
    int         lit;
    int         bad;
    int         steps;
    logic [7:0] held;

    tests = 0;
    fails = 0;
    pwm_tbl[0] = '{duty: 4'd0,  lit: 0};
    pwm_tbl[1] = '{duty: 4'd4,  lit: 4};
    pwm_tbl[2] = '{duty: 4'd15, lit: 16};
    pwm_tbl[3] = '{duty: 4'd1,  lit: 1};
    pwm_tbl[4] = '{duty: 4'd9,  lit: 9};
    chase_exp  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    bounce_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Power-on reset
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; rate = 4'd0; duty = 4'd15;
    load = 1'b0; load_pat = 8'h00;
    cyc(2);
    chk("rst_led", led, 8'h00);
    chk("rst_step", step, 1'b0);
    chk("rst_dir", dir, 1'b0);
    rst_n = 1'b1;
    cyc(1);

    // CHASE, rate 0: step every 4 cycles, first one 4 cycles after the reseed
    mode = 2'b01;
    for (int i = 0; i < 8; i++) push(chase_exp[i], 1'b0, 1'b1);
    run_seq("chase", 8, 5, 3);

    // Asynchronous reset in the middle of CHASE
    rst_n = 1'b0;
    #1;
    chk("midrst_led", led, 8'h00);
    chk("midrst_step", step, 1'b0);
    chk("midrst_dir", dir, 1'b0);
    mode = 2'b00; rate = 4'd1;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("midrst_pat", led, 8'h01);
    wait_step("midrst_first", n);
    chk("midrst_first_step", n + 1, 8);

    // BOUNCE, 16 ticks
    rate = 4'd0; mode = 2'b10;
    for (int i = 0; i < 16; i++) push(bounce_exp[i], bounce_dir[i], 1'b1);
    run_seq("bounce", 16, 5, 3);

    // BLINK: reseed from stored pattern (01), then a load coincident with a tick
    mode = 2'b11;
    push(8'h00, 1'b0, 1'b0);
    run_seq("blink", 1, 5, 3);
    cyc(2);
    load = 1'b1; load_pat = 8'hA5;
    cyc(1);
    chk("blink_load_step", step, 1'b1);
    load = 1'b0; load_pat = 8'h00;
    cyc(1);
    chk("blink_load_led", led, 8'hA5);
    push(8'h00, 1'b0, 1'b0);
    push(8'hA5, 1'b0, 1'b0);
    run_seq("blink2", 2, 3, 3);

    // PWM in STATIC with pattern FF
    mode = 2'b00;
    cyc(1);
    load = 1'b1; load_pat = 8'hFF;
    cyc(1);
    load = 1'b0;
    for (int r = 0; r < 5; r++) begin
      duty = pwm_tbl[r].duty;
      cyc(2);
      lit = 0; bad = 0; steps = 0;
      for (int c = 0; c < 16; c++) begin
        cyc(1);
        if (led === 8'hFF) lit++;
        else if (led !== 8'h00) bad++;
        if (step === 1'b1) steps++;
      end
      chk($sformatf("pwm_lit_d%0d", pwm_tbl[r].duty), lit, pwm_tbl[r].lit);
      chk($sformatf("pwm_bad_d%0d", pwm_tbl[r].duty), bad, 0);
      chk($sformatf("static_steps_d%0d", pwm_tbl[r].duty), steps, 4);
    end

    // CHASE at rate 3, then switch to BOUNCE mid-period: divider must be cleared
    duty = 4'd15; rate = 4'd3; mode = 2'b01;
    push(8'h02, 1'b0, 1'b1);
    run_seq("chase_r3", 1, 17, 0);
    cyc(5);
    mode = 2'b10;
    cyc(2);
    chk("reseed_led", led, 8'h01);
    push(8'h02, 1'b0, 1'b1);
    run_seq("bounce_clr", 1, 15, 0);

    // en low: no steps and a frozen pattern for 100 cycles, PWM unaffected
    en = 1'b0;
    held = led;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1);
      if (step !== 1'b0 || led !== held) bad++;
    end
    chk("en_hold_bad", bad, 0);
    chk("en_hold_led", held, 8'h02);
    en = 1'b1;
    push(8'h04, 1'b0, 1'b1);
    run_seq("en_resume", 1, 15, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
